iob_ram_sp_rd_stream: RTL and testbench

//  Read-side initiator for a single-port synchronous RAM (1-cycle registered read, en/we/addr/din/dout).
//  On a start command, reads LEN consecutive words from BASE_ADDR and emits them on a valid/ready stream.

---
 rtl/iob_ram_sp_rd_stream.sv | 197 +++++++++++++++++++
 tb/tb_iob_ram_sp_rd_stream.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/iob_ram_sp_rd_stream.sv
// iob_ram_sp_rd_stream
//   Read-side initiator for a single-port synchronous RAM. A start command
//   reads len consecutive words from base_addr, with the address wrapping
//   modulo 2**ADDR_W. The words are presented on a valid/ready stream.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     start, base_addr,   command strobe and its arguments; the command is
//     len                 taken only while idle
//     busy, done          command in progress / 1-cycle completion pulse
//     ram_en, ram_we,     RAM request side: registered enable and address;
//     ram_addr, ram_din   the write controls are tied off
//     ram_dout            RAM read data, one cycle after ram_en is sampled
//     m_valid, m_ready,   output stream; m_data is the head of the buffer
//     m_data
//
//   state | meaning
//   IDLE  | no command; a start with len=0 only pulses done
//   READ  | issuing reads, throttled by the occupancy count
//   DRAIN | all reads issued, waiting for the final handshake
module iob_ram_sp_rd_stream #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   rd_left_q, rd_left_d;
  logic [ADDR_W:0]   pop_left_q, pop_left_d;
  logic [1:0]        occ_q, occ_d;
  logic              pend_q, pend_d;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] skid0_q, skid0_d;
  logic [DATA_W-1:0] skid1_q, skid1_d;
  logic [1:0]        skid_cnt_q, skid_cnt_d;

  logic              pop;
  logic              head_free;
  logic              took_dout;
  logic [1:0]        cnt_after;
  logic [1:0]        occ_nxt;

  always_comb begin
    state_d    = state_q;
    rd_left_d  = rd_left_q;
    pop_left_d = pop_left_q;
    ram_addr_d = ram_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ram_en_d   = 1'b0;
    pend_d     = ram_en_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    took_dout  = 1'b0;
    cnt_after  = skid_cnt_q;

    pop       = m_valid_q & m_ready;
    head_free = ~m_valid_q | pop;

    // occ counts issued reads whose word has not yet been consumed, not
    // including a read being issued this cycle. Capping it at 3 means at
    // most two words ever sit between the RAM and the output register,
    // yet a new read can still go out every cycle while words are drained.
    occ_nxt = occ_q + 2'(ram_en_q) - 2'(pop);
    occ_d   = occ_nxt;

    // The head register refills from the skid entries first, then directly
    // from the RAM. Any RAM word it does not take is appended to the skid.
    if (head_free) begin
      if (skid_cnt_q != 2'd0) begin
        m_valid_d = 1'b1;
        m_data_d  = skid0_q;
        skid0_d   = skid1_q;
        cnt_after = skid_cnt_q - 2'd1;
      end else if (pend_q) begin
        m_valid_d = 1'b1;
        m_data_d  = ram_dout;
        took_dout = 1'b1;
        cnt_after = 2'd0;
      end else begin
        m_valid_d = 1'b0;
        cnt_after = 2'd0;
      end
    end
    if (pend_q && !took_dout) begin
      if (cnt_after == 2'd0) skid0_d = ram_dout;
      else                   skid1_d = ram_dout;
      skid_cnt_d = cnt_after + 2'd1;
    end else begin
      skid_cnt_d = cnt_after;
    end

    if (pop) pop_left_d = pop_left_q - (ADDR_W+1)'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d     = 1'b1;
            ram_en_d   = 1'b1;
            ram_addr_d = base_addr;
            rd_left_d  = len - (ADDR_W+1)'(1);
            pop_left_d = len;
            state_d    = (len == (ADDR_W+1)'(1)) ? DRAIN : READ;
          end
        end
      end
      READ: begin
        if (occ_nxt < 2'd3) begin
          ram_en_d   = 1'b1;
          ram_addr_d = ram_addr_q + ADDR_W'(1);
          rd_left_d  = rd_left_q - (ADDR_W+1)'(1);
          if (rd_left_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && pop_left_q == (ADDR_W+1)'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_left_q  <= '0;
      pop_left_q <= '0;
      occ_q      <= '0;
      pend_q     <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      skid0_q    <= '0;
      skid1_q    <= '0;
      skid_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_left_q  <= rd_left_d;
      pop_left_q <= pop_left_d;
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
      skid_cnt_q <= skid_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ram_en   = ram_en_q;
  assign ram_we   = 1'b0;
  assign ram_addr = ram_addr_q;
  assign ram_din  = '0;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;

endmodule

// File: tb/tb_iob_ram_sp_rd_stream.sv
module tb_iob_ram_sp_rd_stream;
  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout, m_data;
  logic          m_valid, m_ready;

  iob_ram_sp_rd_stream #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data)
  );

  always #5 clk = ~clk;

  // RAM model: 1-cycle registered read
  logic [DW-1:0] mem [64];
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // reference model: expected word and address sequences per command
  logic [DW-1:0] exq[$];
  logic [AW-1:0] addrq[$];
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;
  int            issued = 0, popped = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  int            ren_n = 0, done_n = 0, hs_n = 0, acc_cyc = 0, first_v = 0, done_cyc = 0;
  logic          seen_v = 1'b0;
  logic [DW-1:0] log_d[$];
  int            log_c[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic nb, nd, hs;
    logic [AW-1:0] a;
    cyc++;
    if (!rst_n) begin
      exq.delete(); addrq.delete();
      exp_busy = 1'b0; exp_done = 1'b0;
      issued = 0; popped = 0; prev_stall = 1'b0;
      return;
    end
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("ram_we", 32'(ram_we), 32'd0);
    chk("ram_din", 32'(ram_din), 32'd0);
    if (done) begin done_n++; done_cyc = cyc; end
    if (ram_en) begin
      ren_n++; issued++;
      if (addrq.size() == 0) chk("extra_read", 32'(addrq.size()), 32'd1);
      else chk("ram_addr", 32'(ram_addr), 32'(addrq.pop_front()));
    end
    chk("outstanding_le2", 32'((issued - popped - int'(m_valid)) <= 2), 32'd1);
    if (prev_stall) begin
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data", 32'(m_data), 32'(prev_data));
    end
    if (m_valid && !seen_v) begin seen_v = 1'b1; first_v = cyc; end
    hs = m_valid && m_ready;
    nb = exp_busy;
    nd = 1'b0;
    if (hs) begin
      popped++; hs_n++;
      log_d.push_back(m_data); log_c.push_back(cyc);
      if (exq.size() == 0) chk("extra_word", 32'(exq.size()), 32'd1);
      else begin
        chk("m_data", 32'(m_data), 32'(exq.pop_front()));
        if (exq.size() == 0) begin nd = 1'b1; nb = 1'b0; end
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    if (start && !exp_busy) begin
      acc_cyc = cyc; seen_v = 1'b0; hs_n = 0; done_n = 0; ren_n = 0;
      log_d.delete(); log_c.delete();
      if (len == 0) nd = 1'b1;
      else begin
        nb = 1'b1;
        for (int k = 0; k < int'(len); k++) begin
          a = base_addr + AW'(k);
          exq.push_back(mem[a]);
          addrq.push_back(a);
        end
      end
    end
    exp_busy = nb;
    exp_done = nd;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int k);
    if (mode == 1) return (k % 6 == 0) || (k % 6 == 3) || (k % 6 == 5);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic check_reset_outputs();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
  endtask

  task automatic burst(input logic [AW-1:0] b, input logic [AW:0] l, input int mode,
                       input bit inject, input int rst_after);
    bit finished = 1'b0;
    start = 1'b1; base_addr = b; len = l; m_ready = rdy(mode, 0);
    step();
    start = 1'b0;
    for (int k = 1; k < 600; k++) begin
      if (rst_after > 0 && hs_n >= rst_after) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        step(); step();
        rst_n = 1'b1;
        return;
      end
      if (!exp_busy && !exp_done && exq.size() == 0) begin finished = 1'b1; break; end
      if (inject && k == 2) begin
        start = 1'b1; base_addr = 6'h20; len = 7'd3;
      end else begin
        start = 1'b0;
      end
      m_ready = rdy(mode, k);
      step();
    end
    start = 1'b0;
    if (!finished) chk("burst_timeout_words_left", 32'(exq.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h90 + 8'(i);
    step(); step();
    check_reset_outputs();
    rst_n = 1'b1;
    step(); step();

    // 1: burst at 0x10, continuous ready, with an ignored start while busy
    burst(6'h10, 7'd4, 0, 1'b1, 0);
    chk("t1_words", 32'(log_d.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_d.size(); i++) begin
      chk("t1_data", 32'(log_d[i]), 32'hA0 + 32'(i));
      chk("t1_consecutive", 32'(log_c[i] - log_c[0]), 32'(i));
    end
    chk("t1_first_valid_latency", 32'(first_v - acc_cyc), 32'd3);
    chk("t1_done_count", 32'(done_n), 32'd1);
    if (log_c.size() == 4) chk("t1_done_after_last", 32'(done_cyc - log_c[3]), 32'd1);
    chk("t1_ram_en_cycles", 32'(ren_n), 32'd4);
    step();

    // 2: same burst under backpressure 1,0,0,1,0,1...
    burst(6'h10, 7'd4, 1, 1'b0, 0);
    chk("t2_words", 32'(log_d.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_d.size(); i++)
      chk("t2_data", 32'(log_d[i]), 32'hA0 + 32'(i));
    chk("t2_done_count", 32'(done_n), 32'd1);
    step();

    // 3: address wrap 0x3E,0x3F,0x00,0x01
    burst(6'h3E, 7'd4, 0, 1'b0, 0);
    chk("t3_words", 32'(log_d.size()), 32'd4);
    if (log_d.size() == 4) begin
      chk("t3_data0", 32'(log_d[0]), 32'hCE);
      chk("t3_data1", 32'(log_d[1]), 32'hCF);
      chk("t3_data2", 32'(log_d[2]), 32'h90);
      chk("t3_data3", 32'(log_d[3]), 32'h91);
    end
    step();

    // 4: zero-length command
    burst(6'h10, 7'd0, 0, 1'b0, 0);
    chk("t4_done_count", 32'(done_n), 32'd1);
    chk("t4_ram_en_cycles", 32'(ren_n), 32'd0);
    step(); step();

    // 5: reset after the third word, then a fresh 2-word command
    burst(6'h00, 7'd8, 0, 1'b0, 3);
    for (int i = 0; i < 4; i++) step();
    burst(6'h00, 7'd2, 0, 1'b0, 0);
    chk("t5_words", 32'(log_d.size()), 32'd2);
    if (log_d.size() == 2) begin
      chk("t5_data0", 32'(log_d[0]), 32'h90);
      chk("t5_data1", 32'(log_d[1]), 32'h91);
    end
    chk("t5_done_count", 32'(done_n), 32'd1);
    step();

    // 6: full depth from 0x05 with random ready
    burst(6'h05, 7'd64, 2, 1'b0, 0);
    chk("t6_words", 32'(log_d.size()), 32'd64);
    if (log_d.size() == 64) begin
      chk("t6_first", 32'(log_d[0]), 32'h95);
      chk("t6_at_top", 32'(log_d[58]), 32'hCF);
      chk("t6_after_wrap", 32'(log_d[59]), 32'h90);
      chk("t6_last", 32'(log_d[63]), 32'h94);
    end
    chk("t6_done_count", 32'(done_n), 32'd1);
    chk("t6_ram_en_cycles", 32'(ren_n), 32'd64);

    for (int i = 0; i < 4; i++) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
